// File: rtl/sd_sector_buffer_if.sv
// +----------------------------------------------------------------------+
// | sd_sector_buffer_if : handshake bundle between sector buffer and SD   |
// | SPI controller.                                          rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

interface sd_sector_buffer_if;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;
  logic [7:0]  sd_din;
  logic        sd_ready_for_next_byte;
  logic        sd_ready;

  modport master (
    output sd_rd, sd_wr, sd_address, sd_din,
    input  sd_dout, sd_byte_available, sd_ready_for_next_byte, sd_ready
  );

  modport slave (
    input  sd_rd, sd_wr, sd_address, sd_din,
    output sd_dout, sd_byte_available, sd_ready_for_next_byte, sd_ready
  );
endinterface

`default_nettype wire

// File: rtl/sd_sector_buffer.sv
// +----------------------------------------------------------------------+
// | sd_sector_buffer : 512-byte host buffer that moves one sector to/from |
// | the SD SPI controller.                                   rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module sd_sector_buffer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned SECTOR_BYTES   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_read,
  input  logic        cmd_write,
  input  logic [31:0] sector,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_wdata,
  input  logic        buf_we,
  output logic [7:0]  buf_rdata,
  sd_sector_buffer_if.master sd
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ISSUE   = 3'd1;
  localparam logic [2:0] c_XFER_RD = 3'd2;
  localparam logic [2:0] c_XFER_WR = 3'd3;
  localparam logic [2:0] c_FINISH  = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;

  localparam int unsigned          c_TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0]   c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]           c_LAST_EDGE = 10'(SECTOR_BYTES - 1);

  logic [7:0]         r_mem [0:SECTOR_BYTES-1];
  logic [2:0]         r_state;
  logic               r_busy, r_done, r_error, r_sd_rd, r_sd_wr;
  logic [31:0]        r_sd_address;
  logic [7:0]         r_rdata;
  logic [8:0]         r_ptr;
  logic [9:0]         r_cnt;
  logic               r_cmd_phase;
  logic [c_TMO_W-1:0] r_tmo;
  logic               r_bav_q, r_bav_q2, r_rfn_q, r_rfn_q2;

  logic       w_bav_edge, w_rfn_edge, w_active, w_timeout;
  logic       w_store, w_mem_we;
  logic [8:0] w_mem_addr;
  logic [7:0] w_mem_data;
  logic       w_unused_sector;

  assign w_unused_sector = &{1'b0, sector[31:23]};

  assign w_bav_edge = r_bav_q & ~r_bav_q2;
  assign w_rfn_edge = r_rfn_q & ~r_rfn_q2;
  assign w_active   = (r_state == c_ISSUE) || (r_state == c_XFER_RD) ||
                      (r_state == c_XFER_WR) || (r_state == c_FINISH);
  assign w_timeout  = w_active && (r_tmo == c_TMO_LAST);

  // Host writes are locked out while busy, so one shared write port suffices.
  assign w_store    = (r_state == c_XFER_RD) && w_bav_edge && !w_timeout;
  assign w_mem_we   = (buf_we && !r_busy) || w_store;
  assign w_mem_addr = w_store ? r_ptr : buf_addr;
  assign w_mem_data = w_store ? sd.sd_dout : buf_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  always_ff @(posedge clk) begin
    if (reset) r_rdata <= 8'd0;
    else       r_rdata <= r_mem[buf_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bav_q  <= 1'b0;
      r_bav_q2 <= 1'b0;
      r_rfn_q  <= 1'b0;
      r_rfn_q2 <= 1'b0;
    end else begin
      r_bav_q  <= sd.sd_byte_available;
      r_bav_q2 <= r_bav_q;
      r_rfn_q  <= sd.sd_ready_for_next_byte;
      r_rfn_q2 <= r_rfn_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_sd_rd      <= 1'b0;
      r_sd_wr      <= 1'b0;
      r_sd_address <= 32'd0;
      r_ptr        <= 9'd0;
      r_cnt        <= 10'd0;
      r_cmd_phase  <= 1'b0;
      r_tmo        <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_active) r_tmo <= r_tmo + c_TMO_W'(1);
      case (r_state)
        c_IDLE: begin
          if ((cmd_read || cmd_write) && sd.sd_ready) begin
            r_sd_address <= {sector[22:0], 9'b0};
            r_error      <= 1'b0;
            r_ptr        <= 9'd0;
            r_cnt        <= 10'd0;
            r_cmd_phase  <= 1'b1;
            r_tmo        <= '0;
            r_busy       <= 1'b1;
            r_sd_rd      <= cmd_read;
            r_sd_wr      <= ~cmd_read;
            r_state      <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          if (!sd.sd_ready) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_state <= r_sd_rd ? c_XFER_RD : c_XFER_WR;
          end
        end
        c_XFER_RD: begin
          if (w_bav_edge) begin
            r_ptr <= r_ptr + 9'd1;
            r_cnt <= r_cnt + 10'd1;
            if (r_cnt == c_LAST_EDGE) r_state <= c_FINISH;
          end else if (sd.sd_ready) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_DONE;
          end
        end
        c_XFER_WR: begin
          // The first strobe is the controller's command phase; sd_din is not consumed.
          if (w_rfn_edge) begin
            if (r_cmd_phase) begin
              r_cmd_phase <= 1'b0;
            end else begin
              r_ptr <= r_ptr + 9'd1;
              r_cnt <= r_cnt + 10'd1;
              if (r_cnt == c_LAST_EDGE) r_state <= c_FINISH;
            end
          end else if (sd.sd_ready) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_DONE;
          end
        end
        c_FINISH: begin
          if (sd.sd_ready) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_DONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
      if (w_timeout) begin
        r_error <= 1'b1;
        r_sd_rd <= 1'b0;
        r_sd_wr <= 1'b0;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= c_DONE;
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign buf_rdata     = r_rdata;
  assign sd.sd_rd      = r_sd_rd;
  assign sd.sd_wr      = r_sd_wr;
  assign sd.sd_address = r_sd_address;
  assign sd.sd_din     = r_mem[r_ptr];

endmodule

`default_nettype wire

// File: doc/sd_sector_buffer.md
Name: sd_sector_buffer

Overview:
- 512-byte sector buffer between the system bus and the SPI-mode SD card controller.
- Host fills or reads the buffer through a byte port, then issues a sector read or write. The block drives the controller's rd/wr/address handshake, captures streamed read bytes and supplies write bytes on demand.
- Sits directly upstream of the SD controller. Reports completion, short transfers and timeouts.

Parameters:
- TIMEOUT_CYCLES, 50_000_000: maximum clk cycles per operation, counted from command accept to completion, before error.
- SECTOR_BYTES, 512: bytes per transfer. Fixed at 512; other values unsupported.

Ports:
- clk  in  1  system clock (50 MHz, same source as controller)
- reset  in  1  synchronous, active-high
- cmd_read  in  1  pulse: read sector into buffer
- cmd_write  in  1  pulse: write buffer to sector
- sector  in  32  sector number, sampled on command accept
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on completion (success or error)
- error  out  1  sticky result of last op; cleared on next accept
- buf_addr  in  9  host byte address
- buf_wdata  in  8  host write data
- buf_we  in  1  host write enable
- buf_rdata  out  8  buffer[buf_addr], registered, 1-cycle latency
- sd_rd  out  1  to controller rd
- sd_wr  out  1  to controller wr
- sd_address  out  32  to controller address (byte address) = {sector[22:0], 9'b0}
- sd_dout  in  8  controller read byte
- sd_byte_available  in  1  controller read strobe (level, held multiple clk)
- sd_din  out  8  controller write byte = buffer[ptr], combinational from registered ptr
- sd_ready_for_next_byte  in  1  controller write strobe (level)
- sd_ready  in  1  controller idle

Behaviour:
- Reset values: busy=0, done=0, error=0, sd_rd=0, sd_wr=0, sd_address=0, buf_rdata=0, ptr=0, state IDLE. Buffer contents are not reset.
- Edge detect: byte_available and ready_for_next_byte are registered once. A rising edge is curr=1 & prev=0. Only rising edges count.
- IDLE:
  - cmd_read (priority over cmd_write when both asserted) or cmd_write while sd_ready=1: latch sector, clear error, ptr=0, edge_count=0, busy=1 -> ISSUE.
  - A command while sd_ready=0 is ignored.
- ISSUE: hold sd_rd or sd_wr high until sd_ready=0 (controller left idle). Then drop it -> XFER_RD or XFER_WR. Never assert sd_rd and sd_wr together.
- XFER_RD: each byte_available rising edge writes sd_dout into buffer[ptr] and increments ptr. After edge 512, go to FINISH.
- XFER_WR:
  - The first ready_for_next_byte rising edge (command phase) does not advance ptr.
  - Each later rising edge increments ptr, because the controller sampled sd_din on that edge.
  - After 512 advancing edges, go to FINISH. ptr wraps to 0 and is not used further.
- FINISH: wait for sd_ready=1 -> DONE.
- XFER early termination: if sd_ready returns to 1 before the count completes, set error=1 -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Timeout: a cycle counter runs from ISSUE through FINISH. On reaching TIMEOUT_CYCLES: error=1, sd_rd=sd_wr=0 -> DONE.
- Host port:
  - buf_we ignored while busy=1.
  - Reads are always allowed; data during XFER is undefined.
  - Host write and read at the same address in one cycle returns old data.
- Buffer: 512x8 single-clock RAM. The host port and the internal port use separate ports (true dual-port or time-shared); both must be inferrable.
- Reset mid-operation: abort immediately with outputs at reset values. The controller is not reset by this block; a subsequent command waits for sd_ready=1.
- Command pulses while busy=1 are ignored.

Test Plan:
- Host writes buffer[i]=i[7:0] for i=0..511, reads back addresses 0, 255 and 511 -> buf_rdata = 0x00, 0xFF, 0xFF, each one cycle after the address.
- Read model: cmd_read with sector=5 -> sd_address=0x00000A00 and sd_rd held until sd_ready=0. Model streams 512 bytes (k^0x5A), each on a multi-cycle byte_available pulse, then sd_ready=1 -> single done pulse, error=0, buffer[k]=k^0x5A.
- Write model: buffer preloaded with 0xC3 at all addresses, cmd_write -> one command-phase edge plus 512 edges. Model captures sd_din at each advancing edge: all 512 values = 0xC3, sd_wr never overlaps sd_rd, done=1, error=0.
- Short read: model returns sd_ready=1 after 100 bytes -> error=1, done pulse, busy=0.
- Timeout: TIMEOUT_CYCLES=1000 and the model never drops sd_ready -> at cycle 1000 sd_rd=0, error=1, done pulse. cmd_read and cmd_write asserted together -> read path taken (sd_rd=1, sd_wr=0).
- Reset asserted mid-XFER_WR -> next cycle busy=0, sd_wr=0, done=0. buf_we during busy leaves the buffer unchanged.
